// File: rtl/calc_core_if.sv
// calc_core_if: pin bundle for the calculator core.
// buttons are raw active-low pushbuttons; segs/digs drive a multiplexed
// common-anode style 7-segment display (segments active-low, digits active-high).
interface calc_core_if #(
  parameter int DIG_N = 3
);
  logic [1:0]       buttons;
  logic [7:0]       segs;
  logic [DIG_N-1:0] digs;

  // Board / test side: drives the buttons, observes the display.
  modport master (
    output buttons,
    input  segs,
    input  digs
  );

  // Core side: samples the buttons, drives the display.
  modport slave (
    input  buttons,
    output segs,
    output digs
  );
endinterface

// File: rtl/calc_core.sv
// calc_core: two-button single-digit calculator with a multiplexed display.
// buttons[0] walks ST_A -> ST_CMD -> ST_B -> ST_EQ; buttons[1] edits the
// value owned by the current state. The ST_EQ screen shows the signed result.
// Optional feature: define CALC_MUL_EN to add a MUL command (a*b); without it
// no multiplier is built and the command toggles between ADD and SUB.
module calc_core #(
  parameter int DIG_N        = 3,
  parameter int DEBOUNCE_CYC = 2500000,
  parameter int SCAN_CYC     = 25000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  calc_core_if.slave io
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int SC_W  = $clog2(SCAN_CYC + 1);
  localparam int IDX_W = $clog2(DIG_N);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIG_N - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;  // segment g only

  typedef enum logic [1:0] {
    ST_A   = 2'd0,
    ST_CMD = 2'd1,
    ST_B   = 2'd2,
    ST_EQ  = 2'd3
  } state_t;

  // Encoding doubles as the code shown on the ST_CMD screen.
  typedef enum logic [1:0] {
    CMD_ADD = 2'd0,
    CMD_SUB = 2'd1,
    CMD_MUL = 2'd2
  } cmd_t;

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      level;        // debounced level, 1 = released
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      click;        // one-cycle press pulses

  // Two-flop synchroniser; idles at the released level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so sync_b takes the old sync_a, giving two real flop stages.
      sync_a <= io.buttons;
      sync_b <= sync_a;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples; pulse on press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level     <= 2'b11;
      // NOTE: this two-entry counter array is plain flops and is reset per element; real RAM arrays are never reset.
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
      click     <= '0;
    end else begin
      click <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync_b[i];
            db_cnt[i] <= '0;
            click[i]  <= ~sync_b[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Calculator state
  // ---------------------------------------------------------------------
  state_t     state;
  logic [3:0] op_a;
  logic [3:0] op_b;
  cmd_t       cmd;

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic cmd_t next_cmd(input cmd_t c);
    cmd_t n;
`ifdef CALC_MUL_EN
    case (c)
      CMD_ADD: n = CMD_SUB;
      CMD_SUB: n = CMD_MUL;
      default: n = CMD_ADD;
    endcase
`else
    n = (c == CMD_ADD) ? CMD_SUB : CMD_ADD;
`endif
    return n;
  endfunction

  // Main FSM: an advance click wins over a simultaneous edit click.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_A;
      op_a  <= 4'd0;
      op_b  <= 4'd0;
      cmd   <= CMD_ADD;
    end else if (click[0]) begin
      case (state)
        ST_A:    state <= ST_CMD;
        ST_CMD:  state <= ST_B;
        ST_B:    state <= ST_EQ;
        default: state <= ST_A;
      endcase
    end else if (click[1]) begin
      case (state)
        ST_A:    op_a <= inc_digit(op_a);
        ST_CMD:  cmd  <= next_cmd(cmd);
        ST_B:    op_b <= inc_digit(op_b);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Result and decimal split
  // ---------------------------------------------------------------------
  logic signed [7:0] a_s;
  logic signed [7:0] b_s;
  logic signed [7:0] result;
  logic        [7:0] mag;
  logic        [3:0] tens;
  logic        [3:0] units;
  logic              neg;

  assign a_s = {4'b0000, op_a};
  assign b_s = {4'b0000, op_b};

  // Signed result, magnitude and its tens/units digits (|result| <= 81).
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    result = a_s + b_s;
    case (cmd)
      CMD_SUB: result = a_s - b_s;
`ifdef CALC_MUL_EN
      CMD_MUL: result = a_s * b_s;
`endif
      default: ;
    endcase
    neg  = result[7];
    mag  = neg ? 8'(-result) : 8'(result);
    tens = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (mag >= 8'(10 * t)) tens = 4'(t);
    end
    units = 4'(mag - 8'(10 * tens));
  end

  // ---------------------------------------------------------------------
  // Display content
  // ---------------------------------------------------------------------
  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  logic [7:0] dig_segs [DIG_N];

  // Per-digit segment pattern for the current state; unused digits stay blank.
  always_comb begin
    for (int i = 0; i < DIG_N; i++) dig_segs[i] = SEG_BLANK;
    case (state)
      ST_A:   dig_segs[0] = glyph(op_a);
      ST_CMD: dig_segs[0] = glyph({2'b00, cmd});
      ST_B:   dig_segs[0] = glyph(op_b);
      default: begin
        dig_segs[0] = glyph(units);
        if (tens != 4'd0) begin
          dig_segs[1] = glyph(tens);
          if (neg) dig_segs[2] = SEG_MINUS;
        end else if (neg) begin
          dig_segs[1] = SEG_MINUS;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------------
  logic [SC_W-1:0]  scan_cnt;
  logic [IDX_W-1:0] dig_idx;
  logic [IDX_W-1:0] next_idx;
  logic [7:0]       segs_q;
  logic [DIG_N-1:0] digs_q;

  // Digit index that will be enabled after the coming edge.
  always_comb begin
    next_idx = dig_idx;
    if (scan_cnt == SC_LAST) begin
      next_idx = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
    end
  end

  // Scan counter and display registers; segs and digs always load on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      digs_q   <= DIG_N'(1);
      segs_q   <= SEG_BLANK;
    end else begin
      scan_cnt <= (scan_cnt == SC_LAST) ? '0 : scan_cnt + 1'b1;
      dig_idx  <= next_idx;
      digs_q   <= DIG_N'(1) << next_idx;
      segs_q   <= dig_segs[next_idx];
    end
  end

  assign io.segs = segs_q;
  assign io.digs = digs_q;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed and randomized checks of calc_core with short
// debounce/scan intervals. A behavioural model (state, a, b, command as
// integers) predicts every digit's segment pattern.
module tb_calc_core;

  localparam int DIG_N = 3;
  localparam int DEB   = 4;
  localparam int SCAN  = 2;
  localparam int HOLD  = DEB + 4;
`ifdef CALC_MUL_EN
  localparam int NCMD = 3;
`else
  localparam int NCMD = 2;
`endif

  localparam logic [7:0] GLYPH [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] MINUS = 8'hBF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  calc_core_if #(.DIG_N(DIG_N)) io ();

  calc_core #(
    .DIG_N       (DIG_N),
    .DEBOUNCE_CYC(DEB),
    .SCAN_CYC    (SCAN)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .io       (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0=A, 1=CMD, 2=B, 3=EQ; command 0=ADD, 1=SUB, 2=MUL.
  int m_state = 0;
  int m_a     = 0;
  int m_b     = 0;
  int m_cmd   = 0;
  logic [7:0] exp_segs [DIG_N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_a     = 0;
    m_b     = 0;
    m_cmd   = 0;
  endtask

  task automatic build_expected();
    int r;
    int mag;
    int pos;
    for (int i = 0; i < DIG_N; i++) exp_segs[i] = BLANK;
    case (m_state)
      0: exp_segs[0] = GLYPH[m_a];
      1: exp_segs[0] = GLYPH[m_cmd];
      2: exp_segs[0] = GLYPH[m_b];
      default: begin
        case (m_cmd)
          0:       r = m_a + m_b;
          1:       r = m_a - m_b;
          default: r = m_a * m_b;
        endcase
        mag = (r < 0) ? -r : r;
        exp_segs[0] = GLYPH[mag % 10];
        pos = 1;
        if (mag >= 10) begin
          exp_segs[1] = GLYPH[mag / 10];
          pos = 2;
        end
        if (r < 0) exp_segs[pos] = MINUS;
      end
    endcase
  endtask

  // Press the buttons in mask (bit set = pressed) long enough to debounce, then release.
  task automatic click(input logic [1:0] mask);
    @(negedge clk);
    io.buttons = ~mask;
    repeat (HOLD) @(negedge clk);
    io.buttons = 2'b11;
    repeat (HOLD) @(negedge clk);
    if (mask[0]) begin
      m_state = (m_state + 1) % 4;
    end else if (mask[1]) begin
      case (m_state)
        0: m_a   = (m_a + 1) % 10;
        1: m_cmd = (m_cmd + 1) % NCMD;
        2: m_b   = (m_b + 1) % 10;
        default: ;
      endcase
    end
  endtask

  // Walk the scan once and compare every digit against the model.
  task automatic check_display(input string tag);
    build_expected();
    for (int i = 0; i < DIG_N; i++) begin
      logic [DIG_N-1:0] want;
      int n;
      want = DIG_N'(1) << i;
      n = 0;
      while (io.digs !== want && n < 4 * DIG_N * SCAN) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("%s_dig%0d_en", tag, i), 32'(io.digs), 32'(want));
      check($sformatf("%s_dig%0d_seg", tag, i), 32'(io.segs), 32'(exp_segs[i]));
    end
  endtask

  task automatic wait_digs(input logic [DIG_N-1:0] want);
    int n;
    n = 0;
    while (io.digs !== want && n < 4 * DIG_N * SCAN) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    io.buttons = 2'b11;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_segs", 32'(io.segs), 32'h0FF);
    check("rst_digs", 32'(io.digs), 32'h001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_display("after_rst");

    // 3-cycle glitch on buttons[1] must not register
    io.buttons = 2'b01;
    repeat (3) @(negedge clk);
    io.buttons = 2'b11;
    repeat (HOLD) @(negedge clk);
    check_display("glitch");

    // Ten inc clicks in ST_A: 1..9 then wrap to 0
    for (int k = 0; k < 10; k++) begin
      click(2'b10);
      check_display($sformatf("inc%0d", k));
    end

    // 3 - 7 = -4
    while (m_a != 3) click(2'b10);
    click(2'b01);
    while (m_cmd != 1) click(2'b10);
    click(2'b01);
    while (m_b != 7) click(2'b10);
    click(2'b01);
    check_display("sub_neg");

    // Digit rotation: each enable held for SCAN cycles
    wait_digs(DIG_N'(4));
    wait_digs(DIG_N'(1));
    for (int k = 0; k < 2 * DIG_N; k++) begin
      logic [DIG_N-1:0] want;
      want = DIG_N'(1) << (k / SCAN);
      check($sformatf("rot%0d", k), 32'(io.digs), 32'(want));
      @(negedge clk);
    end

    // Command cycling in ST_CMD and the largest result
    click(2'b01);
    click(2'b01);
    check_display("cmd_cur");
    click(2'b10);
    check_display("cmd_step1");
    click(2'b10);
    check_display("cmd_step2");
`ifdef CALC_MUL_EN
    while (m_cmd != 2) click(2'b10);
    click(2'b01);
    while (m_b != 9) click(2'b10);
    click(2'b01);
    while (m_state != 0) click(2'b01);
    while (m_a != 9) click(2'b10);
    while (m_state != 3) click(2'b01);
    check_display("mul_81");
`endif

    // Simultaneous clicks: advance wins, edit dropped
    while (m_state != 0) click(2'b01);
    click(2'b10);
    click(2'b11);
    check_display("both_cmd");
    while (m_state != 0) click(2'b01);
    check_display("both_a_kept");

    // Randomized clicks against the model
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [1:0] mask;
      r = int'($urandom_range(0, 9));
      mask = (r < 3) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      click(mask);
      check_display($sformatf("rnd%0d", k));
    end

    // Reset asserted in ST_EQ
    while (m_state != 3) click(2'b01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("eq_rst_segs", 32'(io.segs), 32'h0FF);
    check("eq_rst_digs", 32'(io.digs), 32'h001);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_display("eq_rst_after");

    // Reset mid-debounce aborts the pending click
    @(negedge clk);
    io.buttons = 2'b01;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    io.buttons = 2'b11;
    repeat (HOLD) @(negedge clk);
    check_display("rst_abort");
    click(2'b10);
    check_display("rst_abort_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
